pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LC-3b pipeline.
- Drives the load enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves memory wait stalls, load-use hazards (using the ID/EX ldr_read flag) and taken-branch redirects resolved in MEM.
- Keeps saturating stall and bubble counters for performance debug.

Parameters:
CNT_W, 16, width of the stall_cycles and bubble_cycles counters

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
imem_resp  in  1  instruction memory response for the current fetch
dmem_req  in  1  MEM stage has a data read or write outstanding
dmem_resp  in  1  data memory response
ex_ldr  in  1  ldr_read from ID/EX: the EX-stage instruction is an LDR
ex_dest  in  3  ID/EX destination register
id_src1  in  3  ID-stage source register 1
id_src2  in  3  ID-stage source register 2
id_use1  in  1  ID instruction reads src1
id_use2  in  1  ID instruction reads src2
mem_br_taken  in  1  control transfer taken, resolved in the MEM stage
load_pc  out  1  PC load enable
load_ifid  out  1  IF/ID load enable
load_idex  out  1  ID/EX load enable
load_exmem  out  1  EX/MEM load enable
load_memwb  out  1  MEM/WB load enable
bubble_idex  out  1  ID/EX captures a NOP control word instead of ctrl_in
flush_ifid  out  1  IF/ID captures a NOP
flush_idex  out  1  ID/EX captures a NOP
flush_exmem  out  1  EX/MEM captures a NOP
stall_cycles  out  CNT_W  saturating count of memory-stall cycles
bubble_cycles  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- FSM states: RUN, MEMWAIT, BUBBLE. Outputs are Mealy: a function of the current state and the current inputs.
- mem_busy = (dmem_req & ~dmem_resp) | ~imem_resp.
- lu_hazard = ex_ldr & ((id_use1 & id_src1==ex_dest) | (id_use2 & id_src2==ex_dest)). Computed in hazard_detect.
- Priority per cycle: reset > mem_busy > branch (mem_br_taken or pend_flush) > lu_hazard > normal advance.

Reset (synchronous, active-high):
- state <= RUN; pend_flush <= 0; both counters <= 0.
- While reset is high: all load_* = 1; flush_ifid = flush_idex = flush_exmem = 1; bubble_idex = 0. This clears the pipeline.

mem_busy (any state):
- All load_* = 0; all flush/bubble outputs = 0.
- Next state = MEMWAIT.
- stall_cycles increments, saturating at all-ones.
- If mem_br_taken is seen while mem_busy, set pend_flush <= 1. The redirect is not lost.

Branch (not mem_busy, with mem_br_taken or pend_flush):
- All load_* = 1; flush_ifid = flush_idex = flush_exmem = 1.
- pend_flush <= 0; next state = RUN.
- lu_hazard is ignored this cycle: the ID instruction is being squashed.

Load-use (not mem_busy, no branch, lu_hazard, state != BUBBLE):
- load_pc = load_ifid = 0.
- load_idex = 1 with bubble_idex = 1.
- load_exmem = load_memwb = 1.
- Next state = BUBBLE; bubble_cycles increments, saturating.
- Exactly one bubble per LDR.

BUBBLE state:
- lu_hazard is masked for one cycle. ID/EX now holds the NOP, so ex_ldr is normally 0 anyway.
- Behaves like RUN otherwise; next state = RUN.

Normal advance:
- All load_* = 1; flush/bubble outputs = 0; next state = RUN.

MEMWAIT exit:
- When mem_busy drops, evaluate branch, then lu_hazard, normally in the same cycle.
- Inputs are frozen during the wait, so the decision equals the one at stall entry.

Width rules:
- Register compares are 3-bit equality.
- Counters never wrap: they hold at 2^CNT_W-1.

Decomposition:
- lc3b_types package gains pipe_state_t enum {RUN, MEMWAIT, BUBBLE}.
- lc3b_reg is reused for register ports.
- One sub-module, hazard_detect: combinational lu_hazard from ex_ldr, ex_dest, id_src*, id_use*. It is reused later by the forwarding unit.

Test Plan:
- Reset high 2 cycles, then low with imem_resp=1, dmem_req=0 -> during reset all load_*=1 and all flush_*=1; after reset all load_*=1, flush_*=0, counters 0.
- ex_ldr=1, ex_dest=3, id_src1=3, id_use1=1 for one cycle, then ex_ldr=0 -> cycle 1: load_pc=load_ifid=0, bubble_idex=1, bubble_cycles=1; cycle 2: all load_*=1. Same stimulus with id_use1=0 -> no bubble.
- dmem_req=1, dmem_resp=0 for 5 cycles, then dmem_resp=1 -> all load_*=0 for 5 cycles, stall_cycles=5, all load_*=1 on the resp cycle.
- mem_br_taken=1 coinciding with the lu_hazard condition -> flush_ifid/idex/exmem=1, bubble_idex=0, bubble_cycles unchanged.
- mem_br_taken=1 during imem_resp=0 (3-cycle stall), then mem_br_taken=0 -> loads held 3 cycles; flush_* asserted on the release cycle; pend_flush cleared the next cycle.
- CNT_W=4, force 20 stall cycles -> stall_cycles holds at 15. Assert reset mid-stall -> state RUN and counters 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared LC-3b pipeline types.
//   lc3b_reg     : 3-bit architectural register index
//   pipe_state_t : stall/flush sequencer states
package lc3b_types;

    localparam int unsigned REG_W = 3;

    typedef logic [REG_W-1:0] lc3b_reg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        BUBBLE  = 2'd2
    } pipe_state_t;

endpackage : lc3b_types

// File: rtl/pipeline_ctrl_if.sv
// Control/status bundle between the pipeline datapath and pipeline_ctrl.
//   status  : imem_resp, dmem_req, dmem_resp, ex_ldr, ex_dest, id_src1/2,
//             id_use1/2, mem_br_taken (datapath -> controller)
//   control : load_*, bubble_idex, flush_* (controller -> datapath)
//   debug   : stall_cycles, bubble_cycles (controller -> datapath)
// master = the controller, slave = the datapath.
interface pipeline_ctrl_if
    import lc3b_types::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             ex_ldr;
    lc3b_reg          ex_dest;
    lc3b_reg          id_src1;
    lc3b_reg          id_src2;
    logic             id_use1;
    logic             id_use2;
    logic             mem_br_taken;

    logic             load_pc;
    logic             load_ifid;
    logic             load_idex;
    logic             load_exmem;
    logic             load_memwb;
    logic             bubble_idex;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] bubble_cycles;

    modport master (
        input  imem_resp, dmem_req, dmem_resp, ex_ldr, ex_dest,
               id_src1, id_src2, id_use1, id_use2, mem_br_taken,
        output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
               bubble_idex, flush_ifid, flush_idex, flush_exmem,
               stall_cycles, bubble_cycles
    );

    modport slave (
        output imem_resp, dmem_req, dmem_resp, ex_ldr, ex_dest,
               id_src1, id_src2, id_use1, id_use2, mem_br_taken,
        input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
               bubble_idex, flush_ifid, flush_idex, flush_exmem,
               stall_cycles, bubble_cycles
    );

endinterface : pipeline_ctrl_if

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: the EX-stage LDR writes a register that the
// ID-stage instruction reads.
//   ex_ldr, ex_dest             : ID/EX load flag and destination
//   id_src1/2, id_use1/2        : ID-stage sources and their use flags
//   lu_hazard                   : combinational hazard flag
module hazard_detect
    import lc3b_types::*;
(
    input  logic    ex_ldr,
    input  lc3b_reg ex_dest,
    input  lc3b_reg id_src1,
    input  lc3b_reg id_src2,
    input  logic    id_use1,
    input  logic    id_use2,
    output logic    lu_hazard
);

    assign lu_hazard = ex_ldr & ((id_use1 & (id_src1 == ex_dest)) |
                                 (id_use2 & (id_src2 == ex_dest)));

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
//   clk, reset : pipeline clock, synchronous active-high reset
//   bus        : pipeline_ctrl_if.master (status in, load/flush/bubble and
//                saturating debug counters out)
// Control outputs are Mealy: they react to status inputs in the same cycle.
module pipeline_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipeline_ctrl_if.master   bus
);

    pipe_state_t      state;
    pipe_state_t      state_next;
    logic             pend_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    logic             lu_hazard;
    logic             mem_busy;
    logic             branch;
    logic             do_bubble;

    hazard_detect u_hazard_detect (
        .ex_ldr    (bus.ex_ldr),
        .ex_dest   (bus.ex_dest),
        .id_src1   (bus.id_src1),
        .id_src2   (bus.id_src2),
        .id_use1   (bus.id_use1),
        .id_use2   (bus.id_use2),
        .lu_hazard (lu_hazard)
    );

    // Event decode in priority order: mem_busy > branch > load-use.
    assign mem_busy  = (bus.dmem_req & ~bus.dmem_resp) | ~bus.imem_resp;
    assign branch    = ~mem_busy & (bus.mem_br_taken | pend_flush);
    // BUBBLE masks the hazard so one LDR costs exactly one bubble.
    assign do_bubble = ~mem_busy & ~branch & lu_hazard & (state != BUBBLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = RUN;
        if (mem_busy) begin
            state_next = MEMWAIT;
        end else if (branch) begin
            state_next = RUN;
        end else if (do_bubble) begin
            state_next = BUBBLE;
        end
    end

    // Output logic; reset drives loads and flushes high to clear the pipe.
    always_comb begin
        bus.load_pc     = 1'b0;
        bus.load_ifid   = 1'b0;
        bus.load_idex   = 1'b0;
        bus.load_exmem  = 1'b0;
        bus.load_memwb  = 1'b0;
        bus.bubble_idex = 1'b0;
        bus.flush_ifid  = 1'b0;
        bus.flush_idex  = 1'b0;
        bus.flush_exmem = 1'b0;
        if (reset) begin
            bus.load_pc     = 1'b1;
            bus.load_ifid   = 1'b1;
            bus.load_idex   = 1'b1;
            bus.load_exmem  = 1'b1;
            bus.load_memwb  = 1'b1;
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.flush_exmem = 1'b1;
        end else if (mem_busy) begin
            // everything frozen
        end else if (branch) begin
            bus.load_pc     = 1'b1;
            bus.load_ifid   = 1'b1;
            bus.load_idex   = 1'b1;
            bus.load_exmem  = 1'b1;
            bus.load_memwb  = 1'b1;
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = 1'b1;
            bus.flush_exmem = 1'b1;
        end else if (do_bubble) begin
            bus.load_idex   = 1'b1;
            bus.bubble_idex = 1'b1;
            bus.load_exmem  = 1'b1;
            bus.load_memwb  = 1'b1;
        end else begin
            bus.load_pc     = 1'b1;
            bus.load_ifid   = 1'b1;
            bus.load_idex   = 1'b1;
            bus.load_exmem  = 1'b1;
            bus.load_memwb  = 1'b1;
        end
    end

    // Pending redirect and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_flush <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (mem_busy) begin
            if (stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            // Remember a redirect that arrives while frozen.
            if (bus.mem_br_taken) begin
                pend_flush <= 1'b1;
            end
        end else if (branch) begin
            pend_flush <= 1'b0;
        end else if (do_bubble) begin
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles  = stall_cnt;
    assign bus.bubble_cycles = bubble_cnt;

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl; a CNT_W=4 copy shares the
// stimulus to exercise counter saturation.
module tb_pipeline_ctrl;
    import lc3b_types::*;

    logic clk;
    logic reset;

    pipeline_ctrl_if #(.CNT_W(16)) bus  ();
    pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus4.imem_resp    = bus.imem_resp;
    assign bus4.dmem_req     = bus.dmem_req;
    assign bus4.dmem_resp    = bus.dmem_resp;
    assign bus4.ex_ldr       = bus.ex_ldr;
    assign bus4.ex_dest      = bus.ex_dest;
    assign bus4.id_src1      = bus.id_src1;
    assign bus4.id_src2      = bus.id_src2;
    assign bus4.id_use1      = bus.id_use1;
    assign bus4.id_use2      = bus.id_use2;
    assign bus4.mem_br_taken = bus.mem_br_taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        imem;
        logic        dreq;
        logic        dresp;
        logic        ldr;
        logic [2:0]  dest;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        u1;
        logic        u2;
        logic        br;
        logic [4:0]  exp_load;   // {pc, ifid, idex, exmem, memwb}
        logic        exp_bub;
        logic [2:0]  exp_flush;  // {ifid, idex, exmem}
        logic [15:0] exp_stall;
        logic [15:0] exp_bcnt;
    } vec_t;

    localparam int unsigned NVEC = 29;
    vec_t vecs [NVEC];

    int n_cmp;
    int n_bad;

    function automatic vec_t mk(logic rst, logic imem, logic dreq, logic dresp,
                                logic ldr, logic [2:0] dest, logic [2:0] s1,
                                logic [2:0] s2, logic u1, logic u2, logic br,
                                logic [4:0] ld, logic bub, logic [2:0] fl,
                                logic [15:0] st, logic [15:0] bc);
        vec_t v;
        v.rst = rst; v.imem = imem; v.dreq = dreq; v.dresp = dresp;
        v.ldr = ldr; v.dest = dest; v.s1 = s1; v.s2 = s2;
        v.u1 = u1; v.u2 = u2; v.br = br;
        v.exp_load = ld; v.exp_bub = bub; v.exp_flush = fl;
        v.exp_stall = st; v.exp_bcnt = bc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        bus.imem_resp    = v.imem;
        bus.dmem_req     = v.dreq;
        bus.dmem_resp    = v.dresp;
        bus.ex_ldr       = v.ldr;
        bus.ex_dest      = v.dest;
        bus.id_src1      = v.s1;
        bus.id_src2      = v.s2;
        bus.id_use1      = v.u1;
        bus.id_use2      = v.u2;
        bus.mem_br_taken = v.br;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " load"}, 32'({bus.load_pc, bus.load_ifid, bus.load_idex,
                                   bus.load_exmem, bus.load_memwb}), 32'(v.exp_load));
        check({tag, " bubble_idex"}, 32'(bus.bubble_idex), 32'(v.exp_bub));
        check({tag, " flush"}, 32'({bus.flush_ifid, bus.flush_idex, bus.flush_exmem}),
              32'(v.exp_flush));
        check({tag, " stall_cycles"}, 32'(bus.stall_cycles), 32'(v.exp_stall));
        check({tag, " bubble_cycles"}, 32'(bus.bubble_cycles), 32'(v.exp_bcnt));
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;

        //            rst im dq dr ld ds s1 s2 u1 u2 br  load      b  flush   st  bc
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b111, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 0);
        // load-use on src1, then release
        vecs[2]  = mk(0, 1, 0, 0, 1, 3, 3, 0, 1, 0, 0, 5'b00111, 1, 3'b000, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 3, 3, 0, 1, 0, 0, 5'b11111, 0, 3'b000, 0, 1);
        // same registers, src1 not used
        vecs[4]  = mk(0, 1, 0, 0, 1, 3, 3, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 1);
        vecs[5]  = mk(0, 1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 1);
        // hazard held two cycles: second cycle masked by BUBBLE
        vecs[6]  = mk(0, 1, 0, 0, 1, 3, 3, 0, 1, 0, 0, 5'b00111, 1, 3'b000, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0, 1, 3, 3, 0, 1, 0, 0, 5'b11111, 0, 3'b000, 0, 2);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 2);
        // load-use on src2; near-miss on src2
        vecs[9]  = mk(0, 1, 0, 0, 1, 5, 0, 5, 1, 1, 0, 5'b00111, 1, 3'b000, 0, 2);
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 3);
        vecs[11] = mk(0, 1, 0, 0, 1, 5, 0, 4, 1, 1, 0, 5'b11111, 0, 3'b000, 0, 3);
        // data memory wait 5 cycles, then response
        vecs[12] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 3'b000, 0, 3);
        vecs[13] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 3'b000, 1, 3);
        vecs[14] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 3'b000, 2, 3);
        vecs[15] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 3'b000, 3, 3);
        vecs[16] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 3'b000, 4, 3);
        vecs[17] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 5, 3);
        vecs[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 5, 3);
        // branch wins over load-use
        vecs[19] = mk(0, 1, 0, 0, 1, 3, 3, 0, 1, 0, 1, 5'b11111, 0, 3'b111, 5, 3);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 5, 3);
        // branch during 3-cycle fetch stall, flush on release
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 3'b000, 5, 3);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 3'b000, 6, 3);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 3'b000, 7, 3);
        vecs[24] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b111, 8, 3);
        vecs[25] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 8, 3);
        // load-use resolved on MEMWAIT exit
        vecs[26] = mk(0, 1, 1, 0, 1, 3, 3, 0, 1, 0, 0, 5'b00000, 0, 3'b000, 8, 3);
        vecs[27] = mk(0, 1, 1, 1, 1, 3, 3, 0, 1, 0, 0, 5'b00111, 1, 3'b000, 9, 3);
        vecs[28] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 9, 4);

        drive(vecs[0]);
        @(posedge clk);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // 20 fetch-stall cycles with a redirect pending: saturation on CNT_W=4
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 3'b000, 0, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            drive(v);
        end
        @(posedge clk);
        #1;
        v.rst = 1'b1;
        drive(v);
        @(negedge clk);
        check("sat stall_cycles w16", 32'(bus.stall_cycles), 32'd29);
        check("sat stall_cycles w4", 32'(bus4.stall_cycles), 32'd15);
        check("sat bubble_cycles w4", 32'(bus4.bubble_cycles), 32'd4);
        check("reset mid-stall load", 32'({bus.load_pc, bus.load_ifid, bus.load_idex,
                                           bus.load_exmem, bus.load_memwb}), 32'h1f);
        check("reset mid-stall flush", 32'({bus.flush_ifid, bus.flush_idex,
                                            bus.flush_exmem}), 32'h7);

        // after reset: counters cleared, pending redirect dropped, state RUN
        @(posedge clk);
        #1;
        v = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 0);
        drive(v);
        @(negedge clk);
        check_vec("post-reset", v);
        check("post-reset stall_cycles w4", 32'(bus4.stall_cycles), 32'd0);
        check("post-reset bubble_cycles w4", 32'(bus4.bubble_cycles), 32'd0);

        @(posedge clk);
        #1;
        v = mk(0, 1, 0, 0, 1, 6, 0, 6, 0, 1, 0, 5'b00111, 1, 3'b000, 0, 0);
        drive(v);
        @(negedge clk);
        check_vec("post-reset bubble", v);

        @(posedge clk);
        #1;
        v = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 3'b000, 0, 1);
        drive(v);
        @(negedge clk);
        check_vec("post-reset advance", v);
        check("post-reset bubble_cycles w4 after", 32'(bus4.bubble_cycles), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipeline_ctrl
